chip_drop_controller: RTL and testbench

Move-execution stage that consumes the column-legality result from `check_column` and owns the game board. It accepts a column request, drives the column to `check_column`, and waits for its registered `valid`. On a legal move it animates a falling chip one row per tick, then latches the chip into the current player's array and hands the turn over. The `red_array`/`green_array` outputs feed both `check_column` and the display/win-check logic.

---
 rtl/connect4_pkg.sv | 28 ++
 rtl/chip_drop_controller_if.sv | 27 ++
 rtl/chip_drop_controller_tick.sv | 27 ++
 rtl/chip_drop_controller.sv | 112 +++++++++++
 tb/tb_chip_drop_controller.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
// Shared connect-4 types: board geometry, players, drop FSM states.
// Helper maps a column number to its bit position within a board row.
package connect4_pkg;

  localparam int BOARD_DIM = 16;

  typedef enum logic {
    PLAYER_RED,
    PLAYER_GREEN
  } player_t;

  typedef logic [15:0][15:0] board_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUERY,
    ST_DECIDE,
    ST_FALL
  } drop_state_t;

  // Column c lives at bit [15-c] of each row.
  function automatic logic [3:0] col_bit(
    input logic [3:0] col
  );
    return 4'd15 - col;
  endfunction

endpackage

// File: rtl/chip_drop_controller_if.sv
// Move request channel: requester drives move_req/req_col, the drop
// stage answers with busy, move_done and move_rejected pulses.
interface chip_drop_controller_if;

  logic       move_req;
  logic [3:0] req_col;
  logic       busy;
  logic       move_done;
  logic       move_rejected;

  modport master (
    output move_req,
    output req_col,
    input  busy,
    input  move_done,
    input  move_rejected
  );

  modport slave (
    input  move_req,
    input  req_col,
    output busy,
    output move_done,
    output move_rejected
  );

endinterface

// File: rtl/chip_drop_controller_tick.sv
// drop_tick_counter: counts 0..DROP_TICKS-1 while enabled, wraps to 0.
// Ports: clock, Reset, clear (forces 0), enable, expire (last tick).
module drop_tick_counter #(
  parameter int DROP_TICKS = 4
) (
  input  logic clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(DROP_TICKS - 1);

  logic [7:0] tick;

  assign expire = enable && (tick == LAST);

  always_ff @(posedge clock) begin
    if (Reset || clear) begin
      tick <= 8'd0;
    end else if (enable) begin
      tick <= expire ? 8'd0 : tick + 8'd1;
    end
  end

endmodule

// File: rtl/chip_drop_controller.sv
// Move-execution stage: queries column legality, animates the falling
// chip one row per DROP_TICKS cycles, owns both player boards.
// Ports: clock, Reset, mv (request channel), check_col/valid to the
// legality checker, board arrays, current_player, fall_active/fall_row.
module chip_drop_controller
  import connect4_pkg::*;
#(
  parameter int DROP_TICKS = 4
) (
  input  logic                    clock,
  input  logic                    Reset,
  chip_drop_controller_if.slave   mv,
  output logic [3:0]              check_col,
  input  logic                    valid,
  output board_t                  red_array,
  output board_t                  green_array,
  output logic                    current_player,
  output logic                    fall_active,
  output logic [3:0]              fall_row
);

  drop_state_t state;
  player_t     player;
  logic        expire;
  logic [3:0]  cb;
  board_t      occ;
  logic        land;

  assign current_player = player;
  assign cb             = col_bit(check_col);
  assign occ            = red_array | green_array;

  // Bottom row always lands; otherwise look at the cell just below.
  always_comb begin
    land = 1'b1;
    if (fall_row != 4'd15) begin
      land = occ[fall_row + 4'd1][cb];
    end
  end

  drop_tick_counter #(
    .DROP_TICKS(DROP_TICKS)
  ) u_tick (
    .clock  (clock),
    .Reset  (Reset),
    .clear  (state != ST_FALL),
    .enable (state == ST_FALL),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      state            <= ST_IDLE;
      player           <= PLAYER_RED;
      red_array        <= '0;
      green_array      <= '0;
      check_col        <= 4'd0;
      fall_row         <= 4'd0;
      fall_active      <= 1'b0;
      mv.busy          <= 1'b0;
      mv.move_done     <= 1'b0;
      mv.move_rejected <= 1'b0;
    end else begin
      mv.move_done     <= 1'b0;
      mv.move_rejected <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (mv.move_req) begin
            check_col <= mv.req_col;
            mv.busy   <= 1'b1;
            state     <= ST_QUERY;
          end
        end
        ST_QUERY: begin
          state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (valid) begin
            fall_row    <= 4'd0;
            fall_active <= 1'b1;
            state       <= ST_FALL;
          end else begin
            mv.move_rejected <= 1'b1;
            mv.busy          <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        ST_FALL: begin
          if (expire) begin
            if (land) begin
              if (player == PLAYER_RED) begin
                red_array[fall_row][cb] <= 1'b1;
              end else begin
                green_array[fall_row][cb] <= 1'b1;
              end
              player       <= (player == PLAYER_RED) ?
                              PLAYER_GREEN : PLAYER_RED;
              mv.move_done <= 1'b1;
              mv.busy      <= 1'b0;
              fall_active  <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              fall_row <= fall_row + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_drop_controller.sv
// Directed bench: two drop stages (DROP_TICKS 1 and 4), each with a
// behavioural legality checker; immediate assertions on every check.
module tb_chip_drop_controller;
  import connect4_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic   rst_a = 1'b1;
  logic   rst_b = 1'b1;
  logic   valid_a, valid_b;
  logic [3:0] chk_a, chk_b, row_a, row_b;
  board_t ra, ga, rb, gb;
  logic   pl_a, pl_b, fa_a, fa_b;

  int total = 0;
  int bad   = 0;

  chip_drop_controller_if a_if ();
  chip_drop_controller_if b_if ();

  chip_drop_controller #(.DROP_TICKS(1)) dut_a (
    .clock          (clock),
    .Reset          (rst_a),
    .mv             (a_if),
    .check_col      (chk_a),
    .valid          (valid_a),
    .red_array      (ra),
    .green_array    (ga),
    .current_player (pl_a),
    .fall_active    (fa_a),
    .fall_row       (row_a)
  );

  chip_drop_controller #(.DROP_TICKS(4)) dut_b (
    .clock          (clock),
    .Reset          (rst_b),
    .mv             (b_if),
    .check_col      (chk_b),
    .valid          (valid_b),
    .red_array      (rb),
    .green_array    (gb),
    .current_player (pl_b),
    .fall_active    (fa_b),
    .fall_row       (row_b)
  );

  // Legality checker model: column legal when its top cell is empty.
  always @(posedge clock) begin
    if (rst_a) valid_a <= 1'b0;
    else valid_a <= !(ra[0][~chk_a] | ga[0][~chk_a]);
    if (rst_b) valid_b <= 1'b0;
    else valid_b <= !(rb[0][~chk_b] | gb[0][~chk_b]);
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request; returns in the cycle after E0.
  task automatic issue_a(input logic [3:0] col);
    @(negedge clock);
    a_if.move_req = 1'b1;
    a_if.req_col  = col;
    @(negedge clock);
    a_if.move_req = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] col);
    @(negedge clock);
    b_if.move_req = 1'b1;
    b_if.req_col  = col;
    @(negedge clock);
    b_if.move_req = 1'b0;
  endtask

  // Cycles after E0 until move_done is seen; -1 if the bound expires.
  task automatic wait_done_a(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (a_if.move_done) begin
        n = i;
        break;
      end
    end
  endtask

  board_t snap_r, snap_g, exp_b;
  int     n, peak, rej_seen, hit;
  logic   seen_done;

  initial begin
    a_if.move_req = 1'b0;
    a_if.req_col  = 4'd0;
    b_if.move_req = 1'b0;
    b_if.req_col  = 4'd0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_red", ra, '0);
    chk("rst_green", ga, '0);
    chk("rst_player", pl_a, 1'b0);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_col", chk_a, 4'd0);
    chk("rst_row", row_a, 4'd0);
    chk("rst_fall", fa_a, 1'b0);
    chk("rst_pulses", {a_if.move_done, a_if.move_rejected}, 2'b00);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Empty-board drop, DROP_TICKS=1: done after E18
    issue_a(4'd0);
    chk("t1_busy", a_if.busy, 1'b1);
    repeat (17) @(negedge clock);
    chk("t1_not_early", a_if.move_done, 1'b0);
    @(negedge clock);
    chk("t1_done", a_if.move_done, 1'b1);
    chk("t1_row15", ra[15], 16'h8000);
    chk("t1_player", pl_a, 1'b1);
    chk("t1_idle", a_if.busy, 1'b0);

    // Stacking: green lands in row 14 at E17
    issue_a(4'd0);
    peak = 0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (fa_a && int'(row_a) > peak) peak = int'(row_a);
      if (a_if.move_done) begin
        n = i;
        break;
      end
    end
    chk("t2_latency", n, 17);
    chk("t2_green", ga[14][15], 1'b1);
    chk("t2_peak", peak, 14);
    chk("t2_player", pl_a, 1'b0);

    // Fill column 5 with 16 alternating moves (red first)
    hit = 0;
    for (int k = 0; k < 16; k++) begin
      issue_a(4'd5);
      wait_done_a(n);
      if (n > 0) hit++;
    end
    chk("t3_fills", hit, 16);
    chk("t3_top_green", {ra[0][10], ga[0][10]}, 2'b01);
    chk("t3_bot_red", {ra[15][10], ga[15][10]}, 2'b10);
    chk("t3_player", pl_a, 1'b0);
    snap_r = ra;
    snap_g = ga;

    // Full column rejected after E2
    issue_a(4'd5);
    chk("t3_no_rej_e1", a_if.move_rejected, 1'b0);
    @(negedge clock);
    @(negedge clock);
    chk("t3_rej", a_if.move_rejected, 1'b1);
    chk("t3_no_done", a_if.move_done, 1'b0);
    chk("t3_red_same", ra, snap_r);
    chk("t3_green_same", ga, snap_g);
    chk("t3_player_same", pl_a, 1'b0);
    @(negedge clock);
    chk("t3_rej_pulse", a_if.move_rejected, 1'b0);

    // Busy ignore: column 3 request in the middle of a column-7 fall
    issue_a(4'd7);
    repeat (5) @(negedge clock);
    chk("t4_in_fall", fa_a, 1'b1);
    a_if.move_req = 1'b1;
    a_if.req_col  = 4'd3;
    @(negedge clock);
    a_if.move_req = 1'b0;
    chk("t4_col_held", chk_a, 4'd7);
    rej_seen = 0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      if (a_if.move_rejected) rej_seen++;
      if (a_if.move_done) begin
        n = i;
        break;
      end
      @(negedge clock);
    end
    chk("t4_done", n > 0, 1'b1);
    chk("t4_no_rej", rej_seen, 0);
    chk("t4_row15", ra[15], 16'h8500);
    chk("t4_col3_empty", ra[15][12] | ga[15][12], 1'b0);
    @(negedge clock);
    chk("t4_no_requeue", a_if.busy, 1'b0);

    // move_req together with Reset is dropped
    @(negedge clock);
    rst_a = 1'b1;
    a_if.move_req = 1'b1;
    a_if.req_col  = 4'd2;
    @(negedge clock);
    rst_a = 1'b0;
    a_if.move_req = 1'b0;
    @(negedge clock);
    chk("rr_busy", a_if.busy, 1'b0);
    chk("rr_board", ra | ga, '0);

    // DROP_TICKS=4, empty column: done after E66
    issue_b(4'd0);
    repeat (65) @(negedge clock);
    chk("b_not_early", b_if.move_done, 1'b0);
    @(negedge clock);
    chk("b_done_e66", b_if.move_done, 1'b1);
    chk("b_row15", rb[15], 16'h8000);
    chk("b_player", pl_b, 1'b1);

    // Reset while the chip is on row 6
    issue_b(4'd2);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (fa_b && row_b == 4'd6) begin
        hit = 1;
        break;
      end
    end
    chk("t5_reach_row6", hit, 1);
    rst_b = 1'b1;
    @(negedge clock);
    chk("t5_red_zero", rb, '0);
    chk("t5_green_zero", gb, '0);
    chk("t5_idle", {b_if.busy, fa_b}, 2'b00);
    chk("t5_player", pl_b, 1'b0);
    chk("t5_no_done", b_if.move_done, 1'b0);
    rst_b = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (b_if.move_done) seen_done = 1'b1;
    end
    chk("t5_no_late_done", seen_done, 1'b0);

    // Edge column 15 maps to bit 0
    issue_b(4'd15);
    repeat (66) @(negedge clock);
    chk("t6_done", b_if.move_done, 1'b1);
    chk("t6_row15", rb[15], 16'h0001);
    exp_b = '0;
    exp_b[15] = 16'h0001;
    chk("t6_red_only", rb, exp_b);
    chk("t6_green", gb, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
